uart_ext: RTL and testbench
===========================

// Module: uart_ext
// PURPOSE
// - Parametrised UART endpoint: TX/RX serialisers, each with its own FIFO.
// - Configurable frame format (data bits, parity, stop bits), FIFO depth, per-direction fill counts.
// - Sticky error flags: parity, framing, overrun.
// - RX path is first-word-fall-through. Sits between the debug transport logic and the pads.
// PARAMETERS
// CLK_RATE    100_000_000  system clock in Hz
// BAUD_RATE   115200       line rate; bit period = round(CLK_RATE/BAUD_RATE) clocks, must be >= 8
// DATA_BITS   8            data bits per frame, 5..8, LSB first
// PARITY      0            0 none, 1 odd, 2 even
// STOP_BITS   1            1 or 2
// FIFO_DEPTH  16           entries per FIFO, power of two, >= 2
// PORTS
// CLK_I        in   1              clock, rising edge
// RST_NI       in   1              reset, asynchronous, active-low
// RX_I         in   1              serial in, asynchronous to CLK_I, idle high
// TX_O         out  1              serial out, idle high
// WE_I         in   1              push DSEND_I into TX FIFO
// DSEND_I      in   DATA_BITS      TX data
// TX_READY_O   out  1              TX FIFO not full
// TX_COUNT_O   out  $clog2(D+1)    TX FIFO occupancy (D = FIFO_DEPTH)
// RE_I         in   1              pop RX FIFO head
// DREC_O       out  DATA_BITS      RX FIFO head; valid while RX_VALID_O
// RX_VALID_O   out  1              RX FIFO not empty
// RX_FULL_O    out  1              RX FIFO full
// RX_COUNT_O   out  $clog2(D+1)    RX FIFO occupancy
// CLR_ERR_I    in   1              clear all sticky error flags
// PARITY_ERR_O out  1              sticky: received frame had bad parity
// FRAME_ERR_O  out  1              sticky: stop bit sampled low
// OVERRUN_O    out  1              sticky: good frame dropped because RX FIFO full
// BEHAVIOUR
// - Reset (async assert, sync deassert inside block):
//   - TX_O=1, TX_READY_O=1, RX_VALID_O=0, RX_FULL_O=0, counts=0, DREC_O=0, all error flags=0.
//   - FIFOs are emptied; both FSMs go to IDLE.
//   - Reset mid-frame aborts the frame and TX_O returns high immediately.
// - TX FIFO:
//   - Push when WE_I && TX_READY_O; WE_I while full is ignored.
//   - Push and pop in the same cycle leave the count unchanged.
// - TX FSM IDLE->START->DATA->PARITY(skipped if PARITY=0)->STOP->IDLE:
//   - Each state lasts one bit period; STOP lasts STOP_BITS periods.
//   - Pops the FIFO on entering START.
//   - WE_I at edge k with TX idle and FIFO empty: TX_O low from edge k+2.
//   - If FIFO non-empty at end of STOP, goes directly to START (no idle gap).
// - RX front end: 2-flop synchroniser on RX_I. All sampling is at mid-bit, counted from the detected falling edge.
// - RX FSM IDLE->START->DATA->PARITY->STOP->IDLE:
//   - START re-samples at half period; if high, false start and back to IDLE.
//   - Only the first stop bit is checked.
//   - IDLE is re-entered at the middle of the stop bit, so back-to-back frames are received.
// - Frame completion priority:
//   - Stop low: set FRAME_ERR_O, discard frame.
//   - Else parity bad: set PARITY_ERR_O, discard frame.
//   - Else if FIFO full and no pop this cycle: set OVERRUN_O, discard frame.
//   - Else push the frame.
// - RX FIFO:
//   - Pop when RE_I && RX_VALID_O; RE_I on empty is ignored.
//   - Pop and push in the same cycle while full: both take effect and the count stays D.
//   - DREC_O updates the cycle after a pop. DREC_O=0 while empty.
// - Error flags:
//   - Stay set until CLR_ERR_I.
//   - CLR_ERR_I in the same cycle as a new error event: the flag stays set.
// - Pointers are log2(D) bits and wrap naturally. Full/empty come from the count, never from pointer compare alone.
// TESTING (CLK_RATE=1_600_000, BAUD_RATE=100_000 -> 16 clk/bit unless noted)
// - 8N1, WE_I with 0xA5 -> TX_O low at k+2, then 1,0,1,0,0,1,0,1, then high; 160 clocks total.
// - Loopback TX_O->RX_I with PARITY=2, send 0x00,0xFF,0x3C -> RX_COUNT_O=3, DREC_O pops 0x00,0xFF,0x3C, no error flags.
// - RX frame with stop bit forced low -> FRAME_ERR_O=1, RX_COUNT_O unchanged; CLR_ERR_I pulse -> 0.
// - D=4, send 5 frames with RE_I=0 -> RX_FULL_O=1, OVERRUN_O=1, first 4 bytes kept in order.
// - RX_I low pulse of 4 clocks -> no frame received, no flags set.
// - Assert RST_NI=0 mid TX data bit -> TX_O=1 same cycle, TX_COUNT_O=0, TX_READY_O=1.

Source files
------------

// File: rtl/uart_ext.sv
// uart_ext: UART endpoint with TX and RX serialisers, each with its own FIFO.
// Frame format, FIFO depth and bit timing are set by parameters. The RX FIFO is
// first-word-fall-through, and the error flags are sticky.

// uart_ext_fifo: circular buffer whose occupancy is tracked by a counter.
// Push and pop arrive already qualified from the parent, so this block never
// checks for full or empty itself.
module uart_ext_fifo #(
  parameter int W = 8,
  parameter int D = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(D+1)-1:0] o_count
);
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D+1);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // storage array, no reset needed since occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  // pointers wrap naturally (depth is a power of two); count tracks occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// state  | meaning
// IDLE   | line idle, waiting for FIFO data (TX) or a falling edge (RX)
// START  | start bit (RX: half-period check for a false start)
// DATA   | data bits, LSB first
// PARITY | parity bit, skipped when parity is disabled
// STOP   | stop bit(s); RX leaves at the middle of the first one
module uart_ext #(
  parameter int CLK_RATE   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            CLK_I,
  input  logic                            RST_NI,
  input  logic                            RX_I,
  output logic                            TX_O,
  input  logic                            WE_I,
  input  logic [DATA_BITS-1:0]            DSEND_I,
  output logic                            TX_READY_O,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] TX_COUNT_O,
  input  logic                            RE_I,
  output logic [DATA_BITS-1:0]            DREC_O,
  output logic                            RX_VALID_O,
  output logic                            RX_FULL_O,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] RX_COUNT_O,
  input  logic                            CLR_ERR_I,
  output logic                            PARITY_ERR_O,
  output logic                            FRAME_ERR_O,
  output logic                            OVERRUN_O
);
  localparam int BIT_CLKS = (CLK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int TW       = $clog2(BIT_CLKS);
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] TMR_BIT   = TW'(BIT_CLKS - 1);
  localparam logic [TW-1:0] TMR_HALF  = TW'(BIT_CLKS / 2 - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // reset asserts asynchronously and releases on the clock
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // ---------------- TX path ----------------
  logic                 w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;
  logic [CW-1:0]        w_tx_cnt;
  state_t               r_tx_state, w_tx_next;
  logic [TW-1:0]        r_tx_tmr;
  logic [2:0]           r_tx_bitn;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_line;
  logic                 w_tx_bit;
  logic                 w_tx_tc;

  assign w_tx_push = WE_I && (w_tx_cnt != CNT_FULL);

  uart_ext_fifo #(.W(DATA_BITS), .D(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(CLK_I), .i_rst_n(w_rst_n), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_din(DSEND_I), .o_dout(w_tx_head), .o_count(w_tx_cnt)
  );

  assign w_tx_tc = (r_tx_tmr == '0);

  // TX next state; the FIFO is popped on every entry to START
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    w_tx_bit  = 1'b1;
    case (r_tx_state)
      S_IDLE: begin
        if (w_tx_cnt != '0) begin
          w_tx_next = S_START;
          w_tx_pop  = 1'b1;
        end
      end
      S_START: begin
        w_tx_bit = 1'b0;
        if (w_tx_tc) w_tx_next = S_DATA;
      end
      S_DATA: begin
        w_tx_bit = r_tx_shift[0];
        if (w_tx_tc && r_tx_bitn == LAST_DATA)
          w_tx_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_tx_bit = r_tx_par;
        if (w_tx_tc) w_tx_next = S_STOP;
      end
      S_STOP: begin
        if (w_tx_tc && r_tx_bitn == LAST_STOP) begin
          if (w_tx_cnt != '0) begin
            w_tx_next = S_START;
            w_tx_pop  = 1'b1;
          end else begin
            w_tx_next = S_IDLE;
          end
        end
      end
      default: w_tx_next = S_IDLE;
    endcase
  end

  // TX state, bit timer and shifter; the line is registered to stay glitch-free
  always_ff @(posedge CLK_I or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_tmr   <= TMR_BIT;
      r_tx_bitn  <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_line  <= w_tx_bit;
      if (r_tx_state == S_IDLE) begin
        r_tx_tmr  <= TMR_BIT;
        r_tx_bitn <= '0;
      end else if (w_tx_tc) begin
        r_tx_tmr  <= TMR_BIT;
        r_tx_bitn <= (w_tx_next == r_tx_state) ? r_tx_bitn + 3'd1 : 3'd0;
      end else begin
        r_tx_tmr  <= r_tx_tmr - TW'(1);
      end
      if (w_tx_pop) begin
        r_tx_shift <= w_tx_head;
        r_tx_par   <= (PARITY == 1) ? ~(^w_tx_head) : ^w_tx_head;
      end else if (r_tx_state == S_DATA && w_tx_tc) begin
        r_tx_shift <= r_tx_shift >> 1;
      end
    end
  end

  assign TX_O       = r_tx_line;
  assign TX_READY_O = (w_tx_cnt != CNT_FULL);
  assign TX_COUNT_O = w_tx_cnt;

  // ---------------- RX path ----------------
  logic                 r_rx_s1, r_rx_s2, r_rx_s3;
  logic                 w_rx_fall;
  state_t               r_rx_state, w_rx_next;
  logic [TW-1:0]        r_rx_tmr;
  logic [2:0]           r_rx_bitn;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 w_rx_tc, w_rx_done, w_rx_stop_bad, w_rx_par_bad;
  logic                 w_rx_push, w_rx_pop, w_rx_full;
  logic [DATA_BITS-1:0] w_rx_head;
  logic [CW-1:0]        w_rx_cnt;
  logic                 r_perr, r_ferr, r_ovr;

  // two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge CLK_I or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= RX_I;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end
  assign w_rx_fall = r_rx_s3 && !r_rx_s2;
  assign w_rx_tc   = (r_rx_tmr == '0);

  // RX next state; every sample is taken at the timer's terminal count
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:   if (w_rx_fall) w_rx_next = S_START;
      S_START:  if (w_rx_tc) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (w_rx_tc && r_rx_bitn == LAST_DATA)
                  w_rx_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_rx_tc) w_rx_next = S_STOP;
      S_STOP:   if (w_rx_tc) w_rx_next = S_IDLE;
      default:  w_rx_next = S_IDLE;
    endcase
  end

  // RX state, bit timer and sampling; IDLE preloads a half period for START
  always_ff @(posedge CLK_I or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_state <= S_IDLE;
      r_rx_tmr   <= TMR_HALF;
      r_rx_bitn  <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      if (r_rx_state == S_IDLE) begin
        r_rx_tmr  <= TMR_HALF;
        r_rx_bitn <= '0;
      end else if (w_rx_tc) begin
        r_rx_tmr  <= TMR_BIT;
        r_rx_bitn <= (w_rx_next == r_rx_state) ? r_rx_bitn + 3'd1 : 3'd0;
        if (r_rx_state == S_DATA)   r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
        if (r_rx_state == S_PARITY) r_rx_par   <= r_rx_s2;
      end else begin
        r_rx_tmr  <= r_rx_tmr - TW'(1);
      end
    end
  end

  assign w_rx_done     = (r_rx_state == S_STOP) && w_rx_tc;
  assign w_rx_stop_bad = !r_rx_s2;
  assign w_rx_par_bad  = (PARITY == 1) ? ~(^{r_rx_shift, r_rx_par}) :
                         (PARITY == 2) ?  (^{r_rx_shift, r_rx_par}) : 1'b0;
  assign w_rx_full     = (w_rx_cnt == CNT_FULL);
  assign w_rx_pop      = RE_I && (w_rx_cnt != '0);
  assign w_rx_push     = w_rx_done && !w_rx_stop_bad && !w_rx_par_bad &&
                         (!w_rx_full || w_rx_pop);

  uart_ext_fifo #(.W(DATA_BITS), .D(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(CLK_I), .i_rst_n(w_rst_n), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_din(r_rx_shift), .o_dout(w_rx_head), .o_count(w_rx_cnt)
  );

  // sticky flags; a new event wins over a simultaneous clear
  always_ff @(posedge CLK_I or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_ferr <= (r_ferr && !CLR_ERR_I) || (w_rx_done && w_rx_stop_bad);
      r_perr <= (r_perr && !CLR_ERR_I) || (w_rx_done && !w_rx_stop_bad && w_rx_par_bad);
      r_ovr  <= (r_ovr  && !CLR_ERR_I) ||
                (w_rx_done && !w_rx_stop_bad && !w_rx_par_bad && w_rx_full && !w_rx_pop);
    end
  end

  assign RX_VALID_O   = (w_rx_cnt != '0);
  assign RX_FULL_O    = w_rx_full;
  assign RX_COUNT_O   = w_rx_cnt;
  assign DREC_O       = RX_VALID_O ? w_rx_head : '0;
  assign PARITY_ERR_O = r_perr;
  assign FRAME_ERR_O  = r_ferr;
  assign OVERRUN_O    = r_ovr;
endmodule

// File: tb/tb_uart_ext.sv
// Directed bench for uart_ext. Instance a is 8N1 with depth 16 and RX driven by
// the bench; instance b is 8E1 with depth 4 and TX looped back to RX.
module tb_uart_ext;
  logic       clk;
  logic       rst_n;
  int         n_checks;
  int         n_errors;

  // instance a
  logic       rx_a, tx_a, we_a, re_a, clr_a;
  logic [7:0] din_a, drec_a;
  logic       ready_a, valid_a, full_a, perr_a, ferr_a, ovr_a;
  logic [4:0] txc_a, rxc_a;

  // instance b
  logic       tx_b, we_b, re_b, clr_b;
  logic [7:0] din_b, drec_b;
  logic       ready_b, valid_b, full_b, perr_b, ferr_b, ovr_b;
  logic [2:0] txc_b, rxc_b;

  uart_ext #(.CLK_RATE(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
             .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut_a (
    .CLK_I(clk), .RST_NI(rst_n), .RX_I(rx_a), .TX_O(tx_a),
    .WE_I(we_a), .DSEND_I(din_a), .TX_READY_O(ready_a), .TX_COUNT_O(txc_a),
    .RE_I(re_a), .DREC_O(drec_a), .RX_VALID_O(valid_a), .RX_FULL_O(full_a),
    .RX_COUNT_O(rxc_a), .CLR_ERR_I(clr_a), .PARITY_ERR_O(perr_a),
    .FRAME_ERR_O(ferr_a), .OVERRUN_O(ovr_a)
  );

  uart_ext #(.CLK_RATE(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
             .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
    .CLK_I(clk), .RST_NI(rst_n), .RX_I(tx_b), .TX_O(tx_b),
    .WE_I(we_b), .DSEND_I(din_b), .TX_READY_O(ready_b), .TX_COUNT_O(txc_b),
    .RE_I(re_b), .DREC_O(drec_b), .RX_VALID_O(valid_b), .RX_FULL_O(full_b),
    .RX_COUNT_O(rxc_b), .CLR_ERR_I(clr_b), .PARITY_ERR_O(perr_b),
    .FRAME_ERR_O(ferr_b), .OVERRUN_O(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // serial frame into instance a, 16 clocks per bit, then two idle bit times
  task automatic send_a(input logic [7:0] d, input logic stop_v);
    rx_a = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      tick(16);
    end
    rx_a = stop_v;
    tick(16);
    rx_a = 1'b1;
    tick(32);
  endtask

  logic [7:0] exp_byte;
  logic [7:0] ovr_bytes [5];

  initial begin
    int cyc;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    rx_a = 1'b1; we_a = 1'b0; re_a = 1'b0; clr_a = 1'b0; din_a = 8'h00;
    we_b = 1'b0; re_b = 1'b0; clr_b = 1'b0; din_b = 8'h00;
    tick(3);

    // reset state
    chk("rst_tx_o",     tx_a, 1);
    chk("rst_ready",    ready_a, 1);
    chk("rst_valid",    valid_a, 0);
    chk("rst_full",     full_a, 0);
    chk("rst_txcount",  txc_a, 0);
    chk("rst_rxcount",  rxc_a, 0);
    chk("rst_drec",     drec_a, 0);
    chk("rst_flags",    {perr_a, ferr_a, ovr_a}, 0);
    rst_n = 1'b1;
    tick(5);

    // 8N1 transmit of 0xA5: low from k+2, LSB first, 16 clocks per bit
    we_a = 1'b1; din_a = 8'hA5;
    tick(1);                        // edge k: push
    we_a = 1'b0;
    chk("tx_count_after_push", txc_a, 1);
    tick(1);                        // edge k+1: pop, line still idle
    chk("tx_k1_high", tx_a, 1);
    chk("tx_count_after_pop", txc_a, 0);
    tick(1);                        // edge k+2
    chk("tx_start_k2", tx_a, 0);
    tick(15);
    chk("tx_start_last", tx_a, 0);
    tick(1);
    chk("tx_bit0_first", tx_a, 1);
    tick(8);
    exp_byte = 8'hA5;
    for (int i = 1; i < 9; i++) begin
      tick(16);
      if (i < 8) chk("tx_data_bit", tx_a, exp_byte[i]);
      else       chk("tx_stop_bit", tx_a, 1);
    end
    tick(16);
    chk("tx_idle_after", tx_a, 1);

    // received frame with stop bit low -> framing error, frame dropped
    send_a(8'h5A, 1'b0);
    chk("ferr_set",       ferr_a, 1);
    chk("ferr_no_push",   rxc_a, 0);
    chk("ferr_no_perr",   perr_a, 0);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    chk("ferr_cleared",   ferr_a, 0);

    // good frame into instance a, FWFT head and pop
    send_a(8'hC3, 1'b1);
    chk("rx_good_count",  rxc_a, 1);
    chk("rx_good_valid",  valid_a, 1);
    chk("rx_good_data",   drec_a, 8'hC3);
    chk("rx_good_flags",  {perr_a, ferr_a, ovr_a}, 0);
    re_a = 1'b1;
    tick(1);
    re_a = 1'b0;
    chk("rx_pop_valid",   valid_a, 0);
    chk("rx_pop_drec0",   drec_a, 0);

    // 4-clock low glitch -> false start
    rx_a = 1'b0;
    tick(4);
    rx_a = 1'b1;
    tick(60);
    chk("glitch_count",   rxc_a, 0);
    chk("glitch_flags",   {perr_a, ferr_a, ovr_a}, 0);

    // loopback with even parity
    we_b = 1'b1;
    din_b = 8'h00; tick(1);
    din_b = 8'hFF; tick(1);
    din_b = 8'h3C; tick(1);
    we_b = 1'b0;
    cyc = 0;
    while (rxc_b != 3'd3 && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    chk("loop_timeout",   (cyc < 3000), 1);
    chk("loop_count",     rxc_b, 3);
    chk("loop_d0",        drec_b, 8'h00);
    re_b = 1'b1; tick(1); re_b = 1'b0;
    chk("loop_d1",        drec_b, 8'hFF);
    re_b = 1'b1; tick(1); re_b = 1'b0;
    chk("loop_d2",        drec_b, 8'h3C);
    re_b = 1'b1; tick(1); re_b = 1'b0;
    chk("loop_empty",     valid_b, 0);
    chk("loop_flags",     {perr_b, ferr_b, ovr_b}, 0);

    // overrun: 5 frames into depth-4 RX FIFO; sixth write hits a full TX FIFO
    ovr_bytes[0] = 8'h11; ovr_bytes[1] = 8'h22; ovr_bytes[2] = 8'h37;
    ovr_bytes[3] = 8'h48; ovr_bytes[4] = 8'h55;
    we_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din_b = ovr_bytes[i];
      tick(1);
    end
    chk("txb_count_full", txc_b, 4);
    chk("txb_not_ready",  ready_b, 0);
    din_b = 8'h66;
    tick(1);
    we_b = 1'b0;
    chk("txb_we_full_ignored", txc_b, 4);
    cyc = 0;
    while (ovr_b !== 1'b1 && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    chk("ovr_timeout",    (cyc < 3000), 1);
    chk("ovr_full",       full_b, 1);
    chk("ovr_count",      rxc_b, 4);
    chk("ovr_no_perr",    {perr_b, ferr_b}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_order",    drec_b, ovr_bytes[i]);
      re_b = 1'b1; tick(1); re_b = 1'b0;
    end
    tick(250);
    chk("ovr_nothing_more", rxc_b, 0);
    chk("ovr_sticky",     ovr_b, 1);

    // reset in the middle of a zero data bit
    we_a = 1'b1; din_a = 8'hF0;
    tick(1);
    din_a = 8'h0F;
    tick(1);
    we_a = 1'b0;
    tick(38);
    chk("prerst_tx_low",  tx_a, 0);
    chk("prerst_count",   txc_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_high", tx_a, 1);
    chk("midrst_count",   txc_a, 0);
    chk("midrst_ready",   ready_a, 1);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("postrst_idle",   tx_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
